stream_packer: RTL and testbench



---
 rtl/stream_packer.sv | 141 ++++++++++++++
 tb/tb_stream_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer
//
// Width-upsizing stage for a valid/ready stream. RATIO consecutive DATA_WIDTH
// beats are collected into one DATA_WIDTH*RATIO word, lane 0 first. A word is
// released when all RATIO lanes are filled, or earlier when a beat flagged
// in_last is accepted. Unwritten lanes of an early-closed word read as zero
// and have their keep bits cleared.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input beat (one lane)
//   in_valid   input beat valid
//   in_last    beat closes the current word early (qualified by in_valid)
//   in_ready   stage can accept a beat this cycle (combinational)
//   out_data   packed word, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   out_keep   per-lane valid mask
//   out_last   word was closed by in_last
//   out_valid  output word valid (registered)
//   out_ready  downstream accepts the word
// -----------------------------------------------------------------------------
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4,
    parameter int IDX_WIDTH  = $clog2(RATIO)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int                   OUT_W    = DATA_WIDTH * RATIO;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

    // Accumulator state
    logic [IDX_WIDTH-1:0] r_idx;
    logic [OUT_W-1:0]     r_acc;
    logic [RATIO-1:0]     r_acc_keep;

    // Output register
    logic [OUT_W-1:0]     r_out_data;
    logic [RATIO-1:0]     r_out_keep;
    logic                 r_out_last;
    logic                 r_out_valid;

    // Handshake and next-accumulator wires
    logic                 w_in_ready;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_complete;
    logic [OUT_W-1:0]     w_acc_next;
    logic [RATIO-1:0]     w_keep_next;

    // The stage may take a beat whenever the output register is empty or is
    // being drained this very cycle, which gives back-to-back words.
    assign w_in_ready = ~r_out_valid | out_ready;
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_complete = (r_idx == LAST_IDX) | in_last;

    // Merge the incoming beat into lane r_idx of the accumulator and keep mask.
    always_comb begin
        w_acc_next  = r_acc;
        w_keep_next = r_acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            if (r_idx == IDX_WIDTH'(k)) begin
                w_acc_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                w_keep_next[k]                         = 1'b1;
            end else begin
                w_acc_next[k*DATA_WIDTH +: DATA_WIDTH] = r_acc[k*DATA_WIDTH +: DATA_WIDTH];
                w_keep_next[k]                         = r_acc_keep[k];
            end
        end
    end

    // Accumulator: advance the lane index per beat, clear on a completed word
    // so no stale lane leaks into the following word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_acc      <= '0;
            r_acc_keep <= '0;
        end else if (w_in_fire) begin
            if (w_complete) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_acc_keep <= '0;
            end else begin
                r_idx      <= r_idx + IDX_WIDTH'(1);
                r_acc      <= w_acc_next;
                r_acc_keep <= w_keep_next;
            end
        end else begin
            r_idx      <= r_idx;
            r_acc      <= r_acc;
            r_acc_keep <= r_acc_keep;
        end
    end

    // Output register: a completed word loads (even while the previous one is
    // draining); otherwise a drain just drops valid and leaves the payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_fire && w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_next;
            r_out_keep  <= w_keep_next;
            r_out_last  <= in_last;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_keep  <= r_out_keep;
            r_out_last  <= r_out_last;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_keep  <= r_out_keep;
            r_out_last  <= r_out_last;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_packer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for stream_packer (DATA_WIDTH=8, RATIO=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 time unit after an input change for the combinational in_ready).
// -----------------------------------------------------------------------------
module tb_stream_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_total;
    int n_pass;

    stream_packer #(
        .DATA_WIDTH(8),
        .RATIO     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat, confirm it will be accepted, and let one edge pass.
    task automatic beat(input logic [7:0] d, input logic l);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = l;
        #1;
        chk("in_ready_on_beat", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_data"},  {32'd0, out_data},  {32'd0, d});
        chk({tag, "_keep"},  {60'd0, out_keep},  {60'd0, k});
        chk({tag, "_last"},  {63'd0, out_last},  {63'd0, l});
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data",  {32'd0, out_data},  64'd0);
        chk("rst_out_keep",  {60'd0, out_keep},  64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full word, little-endian lanes, 1-cycle latency
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("t1_no_early_valid", {63'd0, out_valid}, 64'd0);
        beat(8'h44, 1'b0);
        chk_word("t1_word", 32'h44332211, 4'hF, 1'b0);
        idle(1);
        chk("t1_drained", {63'd0, out_valid}, 64'd0);

        // 2: early close with in_last, next beat restarts at lane 0
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        chk_word("t2_early", 32'h0000BBAA, 4'h3, 1'b1);
        beat(8'hCC, 1'b1);
        chk_word("t2_lane0", 32'h000000CC, 4'h1, 1'b1);
        idle(1);

        // 3: backpressure holds the word and blocks input
        out_ready = 1'b0;
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        beat(8'hA4, 1'b0);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk_word("t3_stall", 32'hA4A3A2A1, 4'hF, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("t3_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("t3_word_taken", {63'd0, out_valid}, 64'd0);
        beat(8'h5B, 1'b0);
        beat(8'h5C, 1'b0);
        beat(8'h5D, 1'b0);
        chk_word("t3_after", 32'h5D5C5B5A, 4'hF, 1'b0);
        idle(1);

        // 4: sustained streaming, one word every 4 cycles
        for (int i = 0; i < 16; i++) begin
            beat(8'(i), 1'b0);
            chk("t4_valid_phase", {63'd0, out_valid}, {63'd0, ((i % 4) == 3)});
            if ((i % 4) == 3) begin
                chk("t4_data", {32'd0, out_data},
                    {32'd0, 8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)});
                chk("t4_keep", {60'd0, out_keep}, 64'hF);
            end
        end
        idle(1);

        // 5a: asynchronous reset drops a pending word immediately
        out_ready = 1'b0;
        beat(8'h99, 1'b1);
        chk_word("t5_pending", 32'h00000099, 4'h1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_keep",  {60'd0, out_keep},  64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // 5b: partial word is discarded by reset
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5b_rst_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        chk_word("t5_clean", 32'h04030201, 4'hF, 1'b0);
        idle(1);

        // 6: single-beat packets on consecutive cycles
        beat(8'hE1, 1'b1);
        chk_word("t6_w0", 32'h000000E1, 4'h1, 1'b1);
        beat(8'hE2, 1'b1);
        chk_word("t6_w1", 32'h000000E2, 4'h1, 1'b1);
        beat(8'hE3, 1'b1);
        chk_word("t6_w2", 32'h000000E3, 4'h1, 1'b1);
        idle(1);

        // in_last without in_valid is ignored; in_last on lane 3 gives full mask
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 8'hFF;
        repeat (2) @(negedge clk);
        chk("t7_unqualified_last", {63'd0, out_valid}, 64'd0);
        beat(8'hC0, 1'b0);
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b1);
        chk_word("t7_last_lane3", 32'hC3C2C1C0, 4'hF, 1'b1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
